// File: rtl/mcsr_vec.sv
// mcsr_vec: machine CSR file with an N-line interrupt controller and
// cycle/retire counters.
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   irq_i                  raw interrupt lines, already synchronous to clk_i
//   we_i, addr_i,          CSR write strobe, address, funct3, rs1 data and
//   funct3_i, data_i,      zimm immediate; data_o is the combinational read
//   rs1_i, data_o          of addr_i
//   instr_executed_i       one instruction retired this cycle
//   interrupt_entered_i    EXE takes interrupt irq_id_o this cycle
//   mret_called_i          mret executed
//   npc_r_i                return PC captured into mepc on entry
//   irq_pending_o          mstatus.mie & |(mip & mie)
//   irq_id_o               lowest-index enabled pending line (0 if none)
//   mepc_r_o               current mepc
module mcsr_vec #(
  parameter int                   pc_width_p      = 22,
  parameter int                   num_irq_p       = 4,
  parameter logic [num_irq_p-1:0] irq_edge_mask_p = '0,
  parameter int                   counter_width_p = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [num_irq_p-1:0]  irq_i,
  input  logic                  we_i,
  input  logic [11:0]           addr_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           data_i,
  input  logic [4:0]            rs1_i,
  output logic [31:0]           data_o,
  input  logic                  instr_executed_i,
  input  logic                  interrupt_entered_i,
  input  logic                  mret_called_i,
  input  logic [pc_width_p-1:0] npc_r_i,
  output logic                  irq_pending_o,
  output logic [3:0]            irq_id_o,
  output logic [pc_width_p-1:0] mepc_r_o
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam int          HI_W           = counter_width_p - 32;

  logic                       mstatus_mie, mstatus_mpie;
  logic [num_irq_p-1:0]       mie_en, mip, mip_next, irq_q, irq_rise, pend_vec;
  logic [pc_width_p-1:0]      mepc;
  logic [31:0]                mcause;
  logic [counter_width_p-1:0] mcycle, minstret;
  logic [63:0]                mcycle_ext, minstret_ext;
  logic [31:0]                rd_val, operand, csr_new;
  logic                       csr_wr, cnt_wr, any_pend;

  assign mcycle_ext   = 64'(mcycle);
  assign minstret_ext = 64'(minstret);

  always_comb begin
    rd_val = '0;
    case (addr_i)
      ADDR_MSTATUS: begin
        rd_val[3] = mstatus_mie;
        rd_val[7] = mstatus_mpie;
      end
      ADDR_MIE:       rd_val[16+:num_irq_p] = mie_en;
      ADDR_MEPC:      rd_val[2+:pc_width_p] = mepc;
      ADDR_MCAUSE:    rd_val = mcause;
      ADDR_MIP:       rd_val[16+:num_irq_p] = mip;
      ADDR_MCYCLE:    rd_val = mcycle_ext[31:0];
      ADDR_MCYCLEH:   rd_val = mcycle_ext[63:32];
      ADDR_MINSTRET:  rd_val = minstret_ext[31:0];
      ADDR_MINSTRETH: rd_val = minstret_ext[63:32];
      default:        rd_val = '0;
    endcase
  end

  assign data_o = rd_val;

  // RW/RS/RC all derive the new value from the current read value, so a
  // register only has to pick its own bits out of csr_new.
  assign operand = funct3_i[2] ? {27'b0, rs1_i} : data_i;
  assign csr_wr  = we_i && (funct3_i[1:0] != 2'b00);
  assign cnt_wr  = we_i && (funct3_i[1:0] == 2'b01);

  always_comb begin
    case (funct3_i[1:0])
      2'b01:   csr_new = operand;
      2'b10:   csr_new = rd_val | operand;
      2'b11:   csr_new = rd_val & ~operand;
      default: csr_new = rd_val;
    endcase
  end

  // Fixed priority: the lowest line number wins.
  assign pend_vec = mip & mie_en;
  assign any_pend = |pend_vec;

  always_comb begin
    irq_id_o = '0;
    for (int i = num_irq_p - 1; i >= 0; i--) begin
      if (pend_vec[i]) irq_id_o = 4'(i);
    end
  end

  assign irq_pending_o = mstatus_mie & any_pend;
  assign mepc_r_o      = mepc;

  // Edge lines latch until cleared; a fresh edge beats a clear in the same
  // cycle so no interrupt is lost. Level lines just follow irq_i one cycle
  // late and ignore CSR writes.
  assign irq_rise = irq_i & ~irq_q;

  always_comb begin
    mip_next = mip;
    for (int i = 0; i < num_irq_p; i++) begin
      if (irq_edge_mask_p[i]) begin
        mip_next[i] = irq_rise[i] | (mip[i] &
                      ~((csr_wr && (addr_i == ADDR_MIP) && !csr_new[16+i]) ||
                        (interrupt_entered_i && any_pend && (irq_id_o == 4'(i)))));
      end else begin
        mip_next[i] = irq_i[i];
      end
    end
  end

  // irq_q reloads with the live irq_i during reset so a line held high across
  // reset deassertion is not mistaken for an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_en       <= '0;
      mip          <= '0;
      irq_q        <= irq_i;
      mepc         <= '0;
      mcause       <= '0;
      mcycle       <= '0;
      minstret     <= '0;
    end else begin
      if (mret_called_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b0;
      end else if (interrupt_entered_i) begin
        mstatus_mie  <= 1'b0;
        mstatus_mpie <= mstatus_mie;
      end else if (csr_wr && (addr_i == ADDR_MSTATUS)) begin
        mstatus_mie  <= csr_new[3];
        mstatus_mpie <= csr_new[7];
      end

      if (csr_wr && (addr_i == ADDR_MIE)) mie_en <= csr_new[16+:num_irq_p];

      mip   <= mip_next;
      irq_q <= irq_i;

      if (interrupt_entered_i) begin
        mepc   <= npc_r_i;
        mcause <= {1'b1, 26'b0, 5'(irq_id_o) + 5'd16};
      end else begin
        if (csr_wr && (addr_i == ADDR_MEPC))   mepc   <= csr_new[2+:pc_width_p];
        if (csr_wr && (addr_i == ADDR_MCAUSE)) mcause <= csr_new;
      end

      // A counter write replaces one half and suppresses that cycle's count.
      if (cnt_wr && (addr_i == ADDR_MCYCLE))
        mcycle <= {mcycle[counter_width_p-1:32], operand};
      else if (cnt_wr && (addr_i == ADDR_MCYCLEH))
        mcycle <= {operand[HI_W-1:0], mcycle[31:0]};
      else
        mcycle <= mcycle + 1'b1;

      if (cnt_wr && (addr_i == ADDR_MINSTRET))
        minstret <= {minstret[counter_width_p-1:32], operand};
      else if (cnt_wr && (addr_i == ADDR_MINSTRETH))
        minstret <= {operand[HI_W-1:0], minstret[31:0]};
      else if (instr_executed_i)
        minstret <= minstret + 1'b1;
    end
  end

  // mret and interrupt entry in the same cycle is illegal from EXE.
  assert property (@(posedge clk_i) disable iff (reset_i)
                   !(mret_called_i && interrupt_entered_i));

endmodule
